// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter:
//   - arb_state_e : FSM state encoding (IDLE, BUSY, RESP)
//   - arb_src_e   : requester identifiers (SRC_IF, SRC_D)
//   - DEF_*       : default widths and limits used as parameter defaults
//   - pick_src()  : arbitration rule for the IDLE cycle
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } arb_src_e;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_MAX_D_BURST    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Burst counter width: MAX_D_BURST is limited to 1..15.
  localparam int BURST_W = 4;

  // Data side has priority unless it has already taken its allowance of
  // back-to-back grants while fetch was waiting.
  function automatic arb_src_e pick_src(input logic if_req,
                                        input logic d_req,
                                        input logic burst_full);
    if (d_req && !(if_req && burst_full)) begin
      return SRC_D;
    end
    return SRC_IF;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
// Counts cycles while enabled; flags expiry once the count reaches
// TIMEOUT_CYCLES-1. Used by mem_port_arbiter only when MEM_ARB_TIMEOUT_EN
// is defined.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clr     : synchronous clear of the count (priority over en)
//   en      : count enable
//   expired : high while count == TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and data access (D).
// One transaction at a time: IDLE (arbitrate + capture) -> BUSY (wait for
// mem_ready) -> RESP (one-cycle ack to the granted side) -> IDLE.
// Data has priority; after MAX_D_BURST consecutive D grants with fetch
// pending, fetch wins the next arbitration. All outputs are registered.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN): a BUSY watchdog aborts the
// transaction after TIMEOUT_CYCLES cycles without mem_ready; the ack is then
// issued together with err=1 and rdata is left untouched. Without the macro
// BUSY waits indefinitely and err stays 0.
//
// Ports:
//   clk, rst_n                  : clock (rising edge), async active-low reset
//   if_req/if_addr              : fetch request (level) and address
//   if_ack/if_rdata             : fetch completion pulse and read data
//   d_req/d_we/d_addr/d_wdata   : data request, store flag, address, data
//   d_ack/d_rdata               : data completion pulse and load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata                   : memory request and attributes
//   mem_ready/mem_rdata         : memory completion and read data
//   err                         : timeout flag, coincides with aborted ack
//   busy                        : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_D_BURST    = DEF_MAX_D_BURST,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic              busy
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);

  if (MAX_D_BURST < 1 || MAX_D_BURST > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MAX_D_BURST or TIMEOUT_CYCLES out of range");
  end

  arb_state_e         state, state_nxt;
  arb_src_e           src, src_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
  logic               burst_full;
  arb_src_e           grant_src;
  logic               timeout_hit;

  logic               mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [DATA_W-1:0]  mem_wdata_nxt;
  logic               if_ack_nxt, d_ack_nxt, err_nxt;
  logic [DATA_W-1:0]  if_rdata_nxt, d_rdata_nxt;

  assign burst_full = (burst_cnt == BURST_MAX);
  assign grant_src  = pick_src(if_req, d_req, burst_full);

`ifdef MEM_ARB_TIMEOUT_EN
  logic timer_expired;

  // Count is held at zero outside BUSY so each transaction starts fresh.
  mem_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != BUSY),
    .en      (state == BUSY),
    .expired (timer_expired)
  );

  assign timeout_hit = timer_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src       <= SRC_IF;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      src       <= src_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // ---- next-state and next-output logic ----
  always_comb begin
    state_nxt     = state;
    src_nxt       = src;
    burst_cnt_nxt = burst_cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    err_nxt       = 1'b0;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;

    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nxt   = BUSY;
          mem_req_nxt = 1'b1;
          src_nxt     = grant_src;
          if (grant_src == SRC_D) begin
            mem_we_nxt    = d_we;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            // A D grant with fetch waiting implies burst_cnt < MAX, so the
            // increment can never pass the saturation value.
            burst_cnt_nxt = if_req ? burst_cnt + 1'b1 : '0;
          end else begin
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = if_addr;
            burst_cnt_nxt = '0;
          end
        end
      end

      BUSY: begin
        // mem_ready in the expiry cycle still completes normally.
        if (mem_ready) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          if (src == SRC_IF) begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = mem_rdata;
          end else begin
            d_ack_nxt = 1'b1;
            if (!mem_we) begin
              d_rdata_nxt = mem_rdata;
            end
          end
        end else if (timeout_hit) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          err_nxt     = 1'b1;
          if (src == SRC_IF) begin
            if_ack_nxt = 1'b1;
          end else begin
            d_ack_nxt = 1'b1;
          end
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_ack    <= if_ack_nxt;
      d_ack     <= d_ack_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      err       <= err_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives both requesters and a memory responder with random timing and
// compares the arbiter's outputs cycle by cycle against a transaction-level
// reference model (grant rule, burst allowance, 3-cycle minimum turnaround,
// optional BUSY timeout). Directed phases cover the lone fetch, simultaneous
// requests, the starvation guard, slow memory with spurious mem_ready,
// the timeout (when MEM_ARB_TIMEOUT_EN is defined) and reset during BUSY.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAXB = 4;
  localparam int TO   = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we, mem_ready;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_ack, d_ack, mem_req, mem_we, err, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .MAX_D_BURST    (MAXB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .err       (err),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  // stimulus knobs
  int      p_if, p_d, p_spur, lat_min, lat_max, lat_left;
  bit      fix_rd;
  logic [DW-1:0] fix_rd_val;
  bit      if_hold, d_hold;

  // observations
  bit      gtrace[$];
  logic    prev_mem_req;
  int      busy_obs, err_obs;

  // reference model
  bit      m_txn, m_src_d;
  int      m_bcnt, m_burst, m_free, edge_n;
  logic          exp_mem_req, exp_we, exp_if_ack, exp_d_ack, exp_err, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_if_rdata, exp_d_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_txn = 0; m_src_d = 0; m_bcnt = 0; m_burst = 0; m_free = 0;
    exp_mem_req = 0; exp_we = 0; exp_if_ack = 0; exp_d_ack = 0;
    exp_err = 0; exp_busy = 0; exp_addr = '0; exp_wdata = '0;
    exp_if_rdata = '0; exp_d_rdata = '0;
  endtask

  task automatic finish_txn(input bit timed_out, input logic [DW-1:0] rd);
    m_txn = 0;
    exp_mem_req = 0;
    exp_err = timed_out;
    m_free = edge_n + 2;   // the RESP-exit edge cannot grant
    if (m_src_d) begin
      exp_d_ack = 1;
      if (!timed_out && !exp_we) exp_d_rdata = rd;
    end else begin
      exp_if_ack = 1;
      if (!timed_out) exp_if_rdata = rd;
    end
  endtask

  // Predicts the outputs after the coming rising edge from the inputs
  // that will be present at that edge.
  task automatic model_edge();
    exp_if_ack = 0; exp_d_ack = 0; exp_err = 0;
    if (m_txn) begin
      if (mem_ready) finish_txn(1'b0, mem_rdata);
      else if (TO_EN && m_bcnt == TO - 1) finish_txn(1'b1, '0);
      else m_bcnt++;
    end else if (edge_n >= m_free && (if_req || d_req)) begin
      m_txn = 1; m_bcnt = 0; exp_mem_req = 1;
      if (d_req && !(if_req && m_burst == MAXB)) begin
        m_src_d = 1; exp_addr = d_addr; exp_we = d_we; exp_wdata = d_wdata;
        m_burst = if_req ? m_burst + 1 : 0;
      end else begin
        m_src_d = 0; exp_addr = if_addr; exp_we = 0; m_burst = 0;
      end
    end
    exp_busy = m_txn || exp_if_ack || exp_d_ack;
    edge_n++;
  endtask

  task automatic new_if();
    logic [31:0] r;
    r = $urandom();
    if_req = 1; if_addr = r & 32'h0000_FFFC;
  endtask

  task automatic new_d();
    logic [31:0] r;
    r = $urandom();
    d_req = 1; d_addr = (r & 32'h0000_FFFC) | 32'h8000_0000;
    d_we = ($urandom_range(1) == 1); d_wdata = $urandom();
  endtask

  // One cycle: check at the falling edge, then set up the next inputs.
  task automatic step();
    chk("mem_req", mem_req, exp_mem_req);
    chk("busy", busy, exp_busy);
    chk("if_ack", if_ack, exp_if_ack);
    chk("d_ack", d_ack, exp_d_ack);
    chk("err", err, exp_err);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    if (exp_mem_req) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_we", mem_we, exp_we);
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
    end
    if (mem_req && !prev_mem_req) gtrace.push_back(d_req && (mem_addr == d_addr));
    if (mem_req) busy_obs++;
    if (err) err_obs++;
    prev_mem_req = mem_req;

    if (if_ack) if_hold = 1;
    else if (if_hold) begin
      if_hold = 0;
      if ($urandom_range(99) < p_if) new_if(); else if_req = 0;
    end else if (!if_req && $urandom_range(99) < p_if) new_if();

    if (d_ack) d_hold = 1;
    else if (d_hold) begin
      d_hold = 0;
      if ($urandom_range(99) < p_d) new_d(); else d_req = 0;
    end else if (!d_req && $urandom_range(99) < p_d) new_d();

    if (mem_req) begin
      if (lat_left == 0) begin
        mem_ready = 1; mem_rdata = fix_rd ? fix_rd_val : $urandom();
      end else begin
        mem_ready = 0; mem_rdata = $urandom(); lat_left--;
      end
    end else begin
      lat_left  = $urandom_range(lat_max, lat_min);
      mem_ready = ($urandom_range(99) < p_spur);
      mem_rdata = $urandom();
    end

    if (!rst_n) model_reset(); else model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit pat [10];
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rst_n = 0; if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0;
    d_wdata = '0; mem_ready = 0; mem_rdata = '0;
    p_if = 0; p_d = 0; p_spur = 0; lat_min = 0; lat_max = 0; lat_left = 0;
    fix_rd = 0; fix_rd_val = '0; if_hold = 0; d_hold = 0;
    prev_mem_req = 0; busy_obs = 0; err_obs = 0; edge_n = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // reset state
    repeat (3) step();
    rst_n = 1;
    repeat (2) step();

    // lone fetch
    gtrace.delete();
    if_req = 1; if_addr = 32'h100; fix_rd = 1; fix_rd_val = 32'h13;
    lat_min = 1; lat_max = 1;
    repeat (8) step();
    fix_rd = 0;
    chk("lone_if_rdata", if_rdata, 32'h13);
    chk("lone_grants", gtrace.size(), 1);

    // simultaneous store and fetch
    gtrace.delete();
    lat_min = 0; lat_max = 0;
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    repeat (12) step();
    chk("simul_grants", gtrace.size(), 2);
    if (gtrace.size() >= 2) begin
      chk("simul_first_d", gtrace[0], 1);
      chk("simul_second_if", gtrace[1], 0);
    end

    // starvation guard with both sides always requesting
    gtrace.delete();
    p_if = 100; p_d = 100;
    n = 0;
    while (gtrace.size() < 10 && n < 80) begin step(); n++; end
    p_if = 0; p_d = 0;
    repeat (20) step();
    chk("starve_grants", (gtrace.size() >= 10), 1);
    if (gtrace.size() >= 10)
      for (int i = 0; i < 10; i++) chk($sformatf("starve_order_%0d", i), gtrace[i], pat[i]);

    // slow memory, spurious mem_ready outside BUSY
    busy_obs = 0;
    d_req = 1; d_we = 0; d_addr = 32'h8000_1000; d_wdata = '0;
    lat_min = 9; lat_max = 9; p_spur = 100;
    repeat (20) step();
    chk("slow_busy_cycles", busy_obs, TO_EN ? TO : 10);
    p_spur = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never answers
    err_obs = 0;
    if_req = 1; if_addr = 32'h200; lat_min = 30; lat_max = 30;
    repeat (16) step();
    chk("timeout_err_pulses", err_obs, 1);
`endif

    // randomized traffic
    p_if = 40; p_d = 50; p_spur = 20; lat_min = 0; lat_max = TO_EN ? 12 : 5;
    repeat (3000) step();
    p_if = 0; p_d = 0; lat_max = 0;
    repeat (40) step();

    // reset in the middle of BUSY
    p_spur = 0; lat_min = 20; lat_max = 20;
    d_req = 1; d_we = 0; d_addr = 32'h8000_0040; d_wdata = '0;
    n = 0;
    while (!mem_req && n < 10) begin step(); n++; end
    chk("rst_phase_grant", mem_req, 1);
    step(); step();
    rst_n = 0; if_req = 0; d_req = 0; if_hold = 0; d_hold = 0; mem_ready = 0;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_d_ack", d_ack, 0);
    chk("rst_async_d_rdata", d_rdata, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (IF) and data access (D, fed by the execute stage's mem_addr/mem_wdata and the mem_read/mem_write flags).
- Each requester gets a req/ack handshake. The block sequences one memory transaction at a time through a registered FSM, with data priority and a fetch-starvation guard.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, read/write data width
- MAX_D_BURST, 4, maximum consecutive D grants while IF is pending; range 1..15
- TIMEOUT_CYCLES, 64, BUSY cycles without mem_ready before abort; used only with MEM_ARB_TIMEOUT_EN

Ports:
- clk in 1 system clock, rising edge
- rst_n in 1 asynchronous active-low reset
- if_req in 1 fetch request, level, held until if_ack
- if_addr in ADDR_W fetch address, stable while if_req=1
- if_ack out 1 one-cycle completion pulse to fetch
- if_rdata out DATA_W fetch read data, valid with if_ack
- d_req in 1 data request, level, held until d_ack
- d_we in 1 1=store, 0=load
- d_addr in ADDR_W data address
- d_wdata in DATA_W store data
- d_ack out 1 one-cycle completion pulse to data side
- d_rdata out DATA_W load data, valid with d_ack
- mem_req out 1 memory request, held through BUSY
- mem_we out 1 memory write enable
- mem_addr out ADDR_W memory address
- mem_wdata out DATA_W memory write data
- mem_ready in 1 memory completion, sampled only in BUSY
- mem_rdata in DATA_W memory read data, valid with mem_ready
- err out 1 timeout pulse, coincides with the aborted ack; tied 0 without the macro
- busy out 1 high when FSM is not IDLE

Behaviour:
- Clocking/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. While rst_n=0, FSM=IDLE, all outputs 0, burst counter 0, timer 0.
- Reset during BUSY abandons the transaction; no ack is issued.
- All outputs are registered.
- FSM states:
  - IDLE, grant made: capture the source and its attributes into the mem_* registers, go to BUSY. mem_req rises 1 cycle after the request is sampled.
  - BUSY: hold mem_req and attributes constant. When mem_ready=1, latch mem_rdata into the granted side's rdata register, clear mem_req, go to RESP.
  - RESP: exactly one cycle. ack=1 for the granted source only. All reqs are ignored. Next state is IDLE.
- Minimum transaction: 3 cycles (IDLE→BUSY→RESP) with mem_ready in the first BUSY cycle. The requester drops req or presents a new one in the cycle after ack.
- Arbitration in IDLE:
  - d_req only → D. if_req only → IF.
  - Both pending → D, unless burst_cnt == MAX_D_BURST; then IF.
- burst_cnt:
  - Increments on each D grant made while if_req=1.
  - Resets to 0 on any IF grant, or on a D grant with if_req=0.
  - Saturates at MAX_D_BURST.
- mem_we is captured from d_we on a D grant and forced 0 on an IF grant. mem_wdata is a don't-care on reads but still registered.
- if_rdata and d_rdata hold their last value until the next ack to the same side. A store ack leaves d_rdata unchanged.
- mem_ready outside BUSY is ignored.
- A req rising during BUSY/RESP waits; it is arbitrated on the next IDLE cycle.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A timer counts BUSY cycles from 0. If it reaches TIMEOUT_CYCLES-1 with mem_ready=0, clear mem_req and go to RESP.
  - In RESP, assert the ack with err=1 for that one cycle; rdata is not updated.
  - mem_ready arriving in the timeout cycle wins: normal completion, err=0.
- Undefined: no timer logic, err tied 0, BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg: FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), source IDs (SRC_IF=1'b0, SRC_D=1'b1), default widths.
- Sub-module mem_arb_timer (counter, clear/enable, expiry flag): instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x100, mem_ready one cycle after mem_req, mem_rdata=0x00000013 → mem_addr=0x100, mem_we=0, if_ack pulse 3 cycles after req sampled, if_rdata=0x13.
- Simultaneous req, both held: d_req store 0x2000/0xDEADBEEF, if_req 0x104 → D served first with mem_we=1, then IF. d_rdata unchanged.
- Starvation guard, MAX_D_BURST=4: d_req and if_req held continuously → grant order D,D,D,D,IF,D…; burst_cnt returns to 0 after the IF grant.
- Slow memory: D load, mem_ready after 10 BUSY cycles → mem_req/mem_addr stable all 10 cycles. A spurious mem_ready asserted in IDLE is ignored.
- Reset mid-BUSY: rst_n low during BUSY → mem_req, busy, acks immediately 0. After release with no reqs, FSM stays IDLE.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted → ack+err pulse in the RESP cycle following the 8th BUSY cycle, FSM back to IDLE.
